keypad_color_bank: RTL and testbench



---
 rtl/keypad_color_bank_pkg.sv | 27 ++
 rtl/keypad_scanner.sv | 108 ++++++++++
 rtl/keypad_color_bank.sv | 52 +++++
 tb/tb_keypad_color_bank.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_color_bank_pkg.sv
// Shared definitions for the keypad colour bank: bank geometry, colour codes, key mapping.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package keypad_color_bank_pkg;

  localparam int NPOS = 16;  // rectangles on screen, one per key of the 4x4 pad
  localparam int DW   = 3;   // colour-index width

  // rgb111 codes in colour-ROM order; the bank stores the index, not the code.
  typedef enum logic [2:0] {
    RGB_WHITE   = 3'b111,
    RGB_RED     = 3'b100,
    RGB_GREEN   = 3'b010,
    RGB_BLUE    = 3'b001,
    RGB_YELLOW  = 3'b110,
    RGB_CYAN    = 3'b011,
    RGB_MAGENTA = 3'b101,
    RGB_BLACK   = 3'b000
  } rgb111_e;

  // Key at (row, col) -> bank index, so the keypad layout mirrors the screen
  // layout: top-left key = 15, bottom-right key = 0.
  function automatic logic [3:0] key_idx(input logic [1:0] row, input logic [1:0] col);
    return 4'd15 - {col, row};
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-frame debounce; strobes one accepted single-key press.
// Latency: press strobe one cycle after the frame end at which the matrix has been stable DEB_SCANS frames.
// Backpressure: none; the strobe is a one-cycle pulse with no ready.
//
// Ports: clk/rst (async active-low), col_n one-cold column drive, row_n active-low row sense,
//        press one-cycle accept strobe, idx bank index of the last accepted key (held).
module keypad_scanner
  import keypad_color_bank_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 20
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic       press,
  output logic [3:0] idx
);

  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STW  = $clog2(DEB_SCANS + 1);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_e;

  col_state_e       state_q, state_d;
  logic [DIVW-1:0]  div_q;
  logic [15:0]      raw_q, prev_q, deb_q;
  logic [STW-1:0]   stable_q;
  logic             press_q;
  logic [3:0]       idx_q;

  logic             last_cnt;
  logic             frame_end;
  logic [15:0]      raw_d;
  logic [STW-1:0]   stable_d;
  logic             deb_upd;
  logic [15:0]      new_keys;
  logic             hit;
  logic [3:0]       pos;

  assign last_cnt  = (div_q == DIVW'(SCAN_DIV - 1));
  assign frame_end = last_cnt && (state_q == COL3);

  // Column FSM: column drive decoded from state, advance on the last divider count.
  always_comb begin
    state_d = state_q;
    col_n   = 4'b1111;
    case (state_q)
      COL0: begin col_n = 4'b1110; if (last_cnt) state_d = COL1; end
      COL1: begin col_n = 4'b1101; if (last_cnt) state_d = COL2; end
      COL2: begin col_n = 4'b1011; if (last_cnt) state_d = COL3; end
      COL3: begin col_n = 4'b0111; if (last_cnt) state_d = COL0; end
      default: begin col_n = 4'b1111; state_d = COL0; end
    endcase
  end

  // Frame evaluation works on the vector including the column being latched
  // this cycle, so column 3 is not a frame late.
  always_comb begin
    raw_d = raw_q;
    if (last_cnt) raw_d[4*int'(state_q) +: 4] = ~row_n;

    if (raw_d == prev_q)
      stable_d = (stable_q == STW'(DEB_SCANS)) ? stable_q : stable_q + 1'b1;
    else
      stable_d = STW'(1);

    deb_upd  = frame_end && (stable_d == STW'(DEB_SCANS)) && (raw_d != deb_q);
    new_keys = raw_d & ~deb_q;
    // Only a lone key that is new fires; any multi-key state is ghost-prone
    // and is absorbed into deb silently so partial releases stay quiet.
    hit      = deb_upd && ($countones(raw_d) == 1) && (new_keys != 16'h0000);

    pos = 4'd0;
    for (int p = 0; p < 16; p++) begin
      if (raw_d[p]) pos = 4'(p);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= COL0;
      div_q    <= '0;
      raw_q    <= '0;
      prev_q   <= '0;
      deb_q    <= '0;
      stable_q <= '0;
      press_q  <= 1'b0;
      idx_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      div_q   <= last_cnt ? '0 : div_q + 1'b1;
      press_q <= hit;
      if (last_cnt) raw_q <= raw_d;
      if (frame_end) begin
        prev_q   <= raw_d;
        stable_q <= stable_d;
      end
      if (deb_upd) deb_q <= raw_d;
      if (hit) idx_q <= key_idx(pos[1:0], pos[3:2]);
    end
  end

  assign press = press_q;
  assign idx   = idx_q;

endmodule

// File: rtl/keypad_color_bank.sv
// Keypad-driven 16 x 3-bit colour-index bank feeding the VGA rectangle renderer.
// Latency: bank entry increments on the edge ending the key_valid cycle; read is combinational.
// Backpressure: none; presses are never dropped or stalled.
//
// Ports: clk/rst (async active-low), col_n/row_n keypad matrix, posicion/dirColor renderer
//        read port, key_valid one-cycle press pulse, key_code index of the last press (held).
module keypad_color_bank
  import keypad_color_bank_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 20
) (
  input  logic          clk,
  input  logic          rst,
  output logic [3:0]    col_n,
  input  logic [3:0]    row_n,
  input  logic [3:0]    posicion,
  output logic [DW-1:0] dirColor,
  output logic          key_valid,
  output logic [3:0]    key_code
);

  logic          press;
  logic [3:0]    idx;
  logic [DW-1:0] bank_q [NPOS];

  keypad_scanner #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_SCANS (DEB_SCANS)
  ) u_scanner (
    .clk   (clk),
    .rst   (rst),
    .col_n (col_n),
    .row_n (row_n),
    .press (press),
    .idx   (idx)
  );

  // Colour index wraps 7 -> 0 naturally at DW bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NPOS; i++) bank_q[i] <= '0;
    end else if (press) begin
      bank_q[idx] <= bank_q[idx] + 1'b1;
    end
  end

  assign key_valid = press;
  assign key_code  = idx;
  assign dirColor  = bank_q[posicion];

endmodule

// File: tb/tb_keypad_color_bank.sv
module tb_keypad_color_bank;

  localparam int SCAN_DIV  = 4;
  localparam int DEB_SCANS = 2;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] posicion = 4'd0;
  logic [2:0] dirColor;
  logic       key_valid;
  logic [3:0] key_code;

  logic [15:0] keys = 16'h0000;  // pressed keys, bit 4*col+row

  int         tests = 0;
  int         fails = 0;
  int         pulses = 0;
  logic [3:0] exp_q [$];
  logic [2:0] model [16];
  bit         chk_next = 1'b0;

  keypad_color_bank #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_SCANS (DEB_SCANS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .posicion  (posicion),
    .dirColor  (dirColor),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col_n[c]) row_n = row_n & ~keys[4*c +: 4];
    end
  end

  // Advance n cycles; at each falling edge drain the scoreboard on key_valid.
  task automatic step_cycles(input int n);
    logic [3:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 16; i++) model[i] = 3'd0;
        chk_next = 1'b0;
        tests++;
        if (key_valid !== 1'b0) begin
          fails++;
          $display("FAIL valid_in_reset: got %b expected 0", key_valid);
        end
      end else begin
        if (chk_next) begin
          chk_next = 1'b0;
          tests++;
          if (dirColor !== model[posicion]) begin
            fails++;
            $display("FAIL read_after_write pos %0d: got %0d expected %0d", posicion, dirColor, model[posicion]);
          end
        end
        if (key_valid) begin
          pulses++;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_key_valid: got key_code %0d expected no pulse", key_code);
          end else begin
            e = exp_q.pop_front();
            tests++;
            if (key_code !== e) begin
              fails++;
              $display("FAIL key_code: got %0d expected %0d", key_code, e);
            end
            tests++;
            if (dirColor !== model[posicion]) begin
              fails++;
              $display("FAIL read_during_write pos %0d: got %0d expected %0d", posicion, dirColor, model[posicion]);
            end
            model[e] = model[e] + 3'd1;
            chk_next = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] one;
    logic [3:0] exp_col;
    one = 4'b0001;
    #2 rst = 1'b0;
    step_cycles(3);
    tests++;
    if (col_n !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0) begin
      fails++;
      $display("FAIL reset_outputs: got col_n %b valid %b code %0d expected 1110 0 0", col_n, key_valid, key_code);
    end
    for (int p = 0; p < 16; p++) begin
      posicion = 4'(p);
      step_cycles(1);
      tests++;
      if (dirColor !== 3'd0) begin
        fails++;
        $display("FAIL reset_bank pos %0d: got %0d expected 0", p, dirColor);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(one << (i / 4));
      tests++;
      if (col_n !== exp_col) begin
        fails++;
        $display("FAIL col_scan cycle %0d: got %b expected %b", i, col_n, exp_col);
      end
      step_cycles(1);
    end
    step_cycles(3 * FRAME);
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL idle_pulses: got %0d expected 0", pulses);
    end
  endtask

  task automatic test_single_press;
    pulses = 0;
    exp_q.push_back(4'd15);
    keys[0] = 1'b1;               // r0/c0
    step_cycles(5 * FRAME);
    keys = 16'h0000;
    step_cycles(4 * FRAME);
    tests++;
    if (pulses != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_press_count: got %0d pulses expected 1", pulses);
    end
    for (int p = 0; p < 16; p++) begin
      posicion = 4'(p);
      step_cycles(1);
      tests++;
      if (dirColor !== ((p == 15) ? 3'd1 : 3'd0)) begin
        fails++;
        $display("FAIL single_press_bank pos %0d: got %0d expected %0d", p, dirColor, (p == 15) ? 1 : 0);
      end
    end
  endtask

  task automatic test_wrap;
    logic [2:0] expv;
    pulses = 0;
    posicion = 4'd0;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(4'd0);
      keys[15] = 1'b1;            // r3/c3
      step_cycles(4 * FRAME);
      keys = 16'h0000;
      step_cycles(4 * FRAME);
      expv = 3'(k + 1);
      tests++;
      if (dirColor !== expv) begin
        fails++;
        $display("FAIL wrap_step %0d: got %0d expected %0d", k, dirColor, expv);
      end
    end
    tests++;
    if (pulses != 8 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_count: got %0d pulses expected 8", pulses);
    end
  endtask

  task automatic test_bounce;
    pulses = 0;
    posicion = 4'd6;
    exp_q.push_back(4'd6);
    keys[9] = 1'b1;               // r1/c2
    for (int t = 0; t < 5; t++) begin
      step_cycles(3);
      keys[9] = ~keys[9];
    end
    keys[9] = 1'b1;
    step_cycles(3 * FRAME);
    keys = 16'h0000;
    step_cycles(4 * FRAME);
    tests++;
    if (pulses != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bounce_count: got %0d pulses expected 1", pulses);
    end
    tests++;
    if (dirColor !== 3'd1) begin
      fails++;
      $display("FAIL bounce_bank: got %0d expected 1", dirColor);
    end
  endtask

  task automatic test_ghost;
    pulses = 0;
    keys[0] = 1'b1;               // r0/c0
    keys[6] = 1'b1;               // r2/c1
    step_cycles(4 * FRAME);
    keys[0] = 1'b0;
    step_cycles(4 * FRAME);
    keys[6] = 1'b0;
    step_cycles(4 * FRAME);
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL ghost_count: got %0d pulses expected 0", pulses);
    end
    for (int p = 0; p < 16; p++) begin
      posicion = 4'(p);
      step_cycles(1);
      tests++;
      if (dirColor !== ((p == 15 || p == 6) ? 3'd1 : 3'd0)) begin
        fails++;
        $display("FAIL ghost_bank pos %0d: got %0d expected %0d", p, dirColor, (p == 15 || p == 6) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_held;
    pulses = 0;
    keys[4] = 1'b1;               // r0/c1
    step_cycles(8);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      posicion = (i < 5) ? 4'd15 : 4'd6;
      step_cycles(1);
      tests++;
      if (dirColor !== 3'd0 || col_n !== 4'b1110) begin
        fails++;
        $display("FAIL held_reset_state %0d: got bank %0d col_n %b expected 0 1110", i, dirColor, col_n);
      end
    end
    rst = 1'b1;
    exp_q.push_back(4'd11);
    posicion = 4'd11;
    step_cycles(5 * FRAME);
    keys = 16'h0000;
    step_cycles(4 * FRAME);
    tests++;
    if (pulses != 1 || exp_q.size() != 0 || key_code !== 4'd11) begin
      fails++;
      $display("FAIL held_press: got %0d pulses code %0d expected 1 pulse code 11", pulses, key_code);
    end
    for (int p = 0; p < 16; p++) begin
      posicion = 4'(p);
      step_cycles(1);
      tests++;
      if (dirColor !== ((p == 11) ? 3'd1 : 3'd0)) begin
        fails++;
        $display("FAIL held_bank pos %0d: got %0d expected %0d", p, dirColor, (p == 11) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_wrap();
    test_bounce();
    test_ghost();
    test_reset_held();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
